// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory write port
// Optional build macro: IMEM_LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte to the frame)
// Frame: LEN_HI, LEN_LO (word count N), then N big-endian 32-bit words; the CPU is held
// in reset until every word has been written.
module imem_loader #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_BYTE,
    S_WRITE,
    S_DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        n_q, n_d;
  logic [31:0]        wd_q, wd_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [15:0]        word_idx_q, word_idx_d;
  logic               imem_we_q;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic [31:0]        imem_wdata_q;
  logic               cpu_hold_q, done_q, error_q;
  logic               rdy_state;
  logic               xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  // States that consume stream bytes; never ready while reset is held
  always_comb begin
    rdy_state = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_BYTE: rdy_state = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                     rdy_state = 1'b1;
`endif
      default:                    rdy_state = 1'b0;
    endcase
  end

  assign in_ready = rdy_state & reset;
  assign xfer     = in_valid & in_ready;

  // Next-state and datapath update for the frame parser
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wd_d       = wd_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          n_d     = {in_byte, n_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          n_d = {n_q[15:8], in_byte};
          if (n_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, n_d} > DEPTH_L) begin
            state_d = S_ERR;
          end else begin
            state_d = S_BYTE;
          end
        end
      end
      S_BYTE: begin
        if (xfer) begin
          wd_d       = {wd_q[23:0], in_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_byte;
`endif
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_BYTE;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the next state
  // so the write strobe lines up with the WRITE state and done follows it by one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_LEN_HI;
      n_q          <= '0;
      wd_q         <= '0;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      wd_q       <= wd_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      imem_we_q  <= (state_d == S_WRITE);
      if (state_d == S_WRITE) begin
        imem_addr_q  <= {word_idx_q[ADDR_W-3:0], 2'b00};
        imem_wdata_q <= wd_d;
      end
      cpu_hold_q <= (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader (honours IMEM_LOADER_CHECKSUM_EN)
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold, done, error;

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_count = 0;
  int gap = 0;
  logic [7:0]  xor_acc = 8'h00;
  logic [41:0] exp_q[$];

  imem_loader #(.ADDR_W(10), .DEPTH_WORDS(256)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe is matched against the oldest expected write
  always @(negedge clk) begin
    logic [41:0] e;
    if (imem_we === 1'b1) begin
      we_count++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {22'd0, imem_addr}, {22'd0, e[41:32]});
        chk("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_addr_data", {22'd0, imem_addr} | imem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    we_count = 0;
    xor_acc = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte = b;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      chk("send_accept", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] b);
    xor_acc = xor_acc ^ b;
    send_byte(b);
  endtask

  task automatic send_word(input logic [9:0] addr, input logic [31:0] w, input bit expect_write);
    if (expect_write) exp_q.push_back({addr, w});
    send_data(w[31:24]);
    send_data(w[23:16]);
    send_data(w[15:8]);
    send_data(w[7:0]);
  endtask

  task automatic send_csum(input logic [7:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(c);
`else
    c = c;
`endif
  endtask

  task automatic wait_end(input string name);
    int k;
    k = 0;
    while (done !== 1'b1 && error !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_end_timeout"}, {31'd0, k < 20}, 32'd1);
  endtask

  task automatic expect_done(input string name, input int writes);
    wait_end(name);
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({name, "_error"}, {31'd0, error}, 32'd0);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk({name, "_we_count"}, we_count, writes);
    chk({name, "_sb_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] i8;

    // 1: reset state and ready afterwards
    do_reset(2);

    // 2: two words, back to back, with exact latency
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(10'h000, 32'h20080005, 1'b1);
    send_word(10'h004, 32'h01095020, 1'b1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    chk("lat_we_t1", {31'd0, imem_we}, 32'd1);
    chk("lat_done_t1", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("lat_done_t2", {31'd0, done}, 32'd1);
    chk("lat_hold_t2", {31'd0, cpu_hold}, 32'd0);
`endif
    send_csum(8'h55);
    expect_done("t2", 2);

    // 3: same frame with 3-cycle gaps between every byte
    do_reset(1);
    gap = 3;
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(10'h000, 32'h20080005, 1'b1);
    send_word(10'h004, 32'h01095020, 1'b1);
    send_csum(8'h55);
    gap = 0;
    expect_done("t3", 2);

    // 4: N=257 overflows depth
    do_reset(1);
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    chk("t4_error", {31'd0, error}, 32'd1);
    chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t4_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    in_valid = 1'b1;
    in_byte = 8'hAA;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    chk("t4_in_ready_late", {31'd0, in_ready}, 32'd0);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_we_count", we_count, 32'd0);

    // 5: reset mid-load discards partial word, reload from scratch
    do_reset(1);
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(10'h000, 32'h11223344, 1'b1);
    send_data(8'h55);
    do_reset(1);
    chk("t5_hold_after_rst", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(10'h000, 32'hDEADBEEF, 1'b1);
    send_csum(8'h22);
    expect_done("t5", 1);

    // N=0: empty image completes immediately
    do_reset(1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_csum(8'h00);
    expect_done("n0", 0);

    // N=DEPTH_WORDS boundary: full memory, last write at 0x3FC
    do_reset(1);
    send_byte(8'h01);
    send_byte(8'h00);
    @(negedge clk);
    chk("n256_no_error", {31'd0, error}, 32'd0);
    chk("n256_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      i8 = 8'(i);
      send_word(10'(i * 4), {i8, 8'hA5, ~i8, 8'h5A}, 1'b1);
    end
    send_csum(xor_acc);
    expect_done("n256", 256);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch
    do_reset(1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(10'h000, 32'h12345678, 1'b1);
    send_byte(8'h08);
    expect_done("t6_ok", 1);

    do_reset(1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(10'h000, 32'h12345678, 1'b1);
    send_byte(8'h09);
    wait_end("t6_bad");
    chk("t6_bad_error", {31'd0, error}, 32'd1);
    chk("t6_bad_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t6_bad_done", {31'd0, done}, 32'd0);
    chk("t6_bad_we_count", we_count, 32'd1);
    chk("t6_bad_sb_drained", exp_q.size(), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
